cpu_ifetch: RTL and testbench

Instruction fetch stage (pipeline stage p1) that drives cpu_decode through p2_instr, p2_pc, p2_instr_valid and p2_bubble. It generates the fetch PC and issues in-order word requests to instruction memory over a request/grant and response-valid bus. Responses are buffered in a small FIFO, so decode stalls and bubbles never drop instructions. Taken jumps from p3 redirect the PC and discard wrong-path responses, including those still in flight.

---
 rtl/cpu_ifetch_pkg.sv | 18 +
 rtl/cpu_ifetch_fifo.sv | 64 ++++++
 rtl/cpu_ifetch.sv | 104 ++++++++++
 tb/tb_cpu_ifetch.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ifetch_pkg.sv
// Shared fetch-stage types and constants: reset vector, instruction width and the
// {pc, instr} entry carried from fetch to decode.
package cpu_ifetch_pkg;

    localparam logic [31:0] CPU_RESET_PC = 32'hFFFF0000;
    localparam int unsigned CPU_INSTR_W  = 32;
    localparam int unsigned CPU_ADDR_W   = 32;

    typedef struct packed {
        logic [CPU_ADDR_W-1:0]  pc;
        logic [CPU_INSTR_W-1:0] instr;
    } fetch_entry_t;

    function automatic logic [CPU_ADDR_W-1:0] word_align(input logic [CPU_ADDR_W-1:0] a);
        return {a[CPU_ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/cpu_ifetch_fifo.sv
// DEPTH-entry response buffer of {pc, instr}; head is read straight from storage registers.
// Clear has priority over push/pop; push and pop together keep the count unchanged.
module cpu_ifetch_fifo
    import cpu_ifetch_pkg::*;
#(
    parameter int unsigned  DEPTH       = 2,
    parameter fetch_entry_t RESET_ENTRY = '0,
    localparam int unsigned PW          = $clog2(DEPTH),
    localparam int unsigned CW          = $clog2(DEPTH) + 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_clear,
    input  fetch_entry_t i_data,
    output logic [CW-1:0] o_count,
    output logic         o_valid,
    output fetch_entry_t o_head
);

    fetch_entry_t  r_mem [DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic          w_full;
    logic          w_do_pop;

    assign w_full   = (r_count == CW'(DEPTH));
    assign w_do_pop = i_pop && (r_count != '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= RESET_ENTRY;
            end
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            // When full, the write slot is the head being popped this cycle.
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count <= r_count + CW'(i_push) - CW'(w_do_pop);
        end
    end

    assign o_count = r_count;
    assign o_valid = (r_count != '0);
    assign o_head  = r_mem[r_rd_ptr];

    assert property (@(posedge clock) disable iff (reset)
        !(i_push && w_full && !w_do_pop && !i_clear));

endmodule

// File: rtl/cpu_ifetch.sv
// Fetch stage p1: credit-limited in-order word requests to imem, responses buffered for decode.
// A p3 redirect clears the buffer and discards every response still in flight.
module cpu_ifetch
    import cpu_ifetch_pkg::*;
#(
    parameter logic [31:0]  RESET_PC = CPU_RESET_PC,
    parameter int unsigned  DEPTH    = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   p2_bubble,
    input  logic                   p3_jump_taken,
    input  logic [31:0]            p3_jump_target,
    output logic                   imem_req,
    output logic [31:0]            imem_addr,
    input  logic                   imem_gnt,
    input  logic                   imem_rvalid,
    input  logic [CPU_INSTR_W-1:0] imem_rdata,
    output logic [CPU_INSTR_W-1:0] p2_instr,
    output logic [31:0]            p2_pc,
    output logic                   p2_instr_valid
);

    localparam int unsigned  CW          = $clog2(DEPTH) + 1;
    localparam int unsigned  IW          = CW + 1;
    localparam fetch_entry_t RESET_ENTRY = {RESET_PC, 32'h0};

    logic [31:0]   r_pc;
    logic [31:0]   r_resp_pc;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_discard;

    logic [CW-1:0] w_fifo_count;
    logic [IW-1:0] w_inflight;
    logic [31:0]   w_target;
    logic          w_flush;
    logic          w_pop;
    logic          w_fire;
    logic          w_drop;
    logic          w_push;
    fetch_entry_t  w_entry;
    fetch_entry_t  w_head;

    assign w_target   = word_align(p3_jump_target);
    assign w_flush    = p3_jump_taken && !stall;
    assign w_pop      = p2_instr_valid && !stall && !p2_bubble;
    assign w_inflight = {1'b0, r_outstanding} + {1'b0, w_fifo_count};

    assign imem_req  = !reset && !w_flush && (w_inflight < IW'(DEPTH));
    assign imem_addr = r_pc;
    assign w_fire    = imem_req && imem_gnt;
    assign w_drop    = (r_discard != '0);
    assign w_push    = imem_rvalid && !w_drop && !w_flush;
    assign w_entry   = {r_resp_pc, imem_rdata};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pc          <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_outstanding <= '0;
            r_discard     <= '0;
        end else if (w_flush) begin
            // Everything still in flight after this cycle belongs to the wrong path.
            r_pc          <= w_target;
            r_resp_pc     <= w_target;
            r_outstanding <= r_outstanding - CW'(imem_rvalid);
            r_discard     <= r_outstanding - CW'(imem_rvalid);
        end else begin
            if (w_fire) begin
                r_pc <= r_pc + 32'd4;
            end
            if (w_push) begin
                r_resp_pc <= r_resp_pc + 32'd4;
            end
            if (imem_rvalid && w_drop) begin
                r_discard <= r_discard - CW'(1);
            end
            r_outstanding <= r_outstanding + CW'(w_fire) - CW'(imem_rvalid);
        end
    end

    cpu_ifetch_fifo #(
        .DEPTH       (DEPTH),
        .RESET_ENTRY (RESET_ENTRY)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clear (w_flush),
        .i_data  (w_entry),
        .o_count (w_fifo_count),
        .o_valid (p2_instr_valid),
        .o_head  (w_head)
    );

    assign p2_instr = w_head.instr;
    assign p2_pc    = w_head.pc;

    assert property (@(posedge clock) disable iff (reset)
        !(imem_rvalid && (r_outstanding == '0)));

endmodule

// File: tb/tb_cpu_ifetch.sv
// Self-checking bench for cpu_ifetch: in-order memory model returning addr^KEY, a queue-level
// reference model compared every cycle, and directed scenarios pinned with literal values.
module tb_cpu_ifetch;
    import cpu_ifetch_pkg::*;

    localparam int unsigned DEPTH = 2;
    localparam logic [31:0] KEY   = 32'h5A5A5A5A;
    localparam logic [31:0] RPC   = 32'hFFFF0000;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall;
    logic        p2_bubble;
    logic        p3_jump_taken;
    logic [31:0] p3_jump_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata  = 32'h0;
    logic [31:0] p2_instr;
    logic [31:0] p2_pc;
    logic        p2_instr_valid;

    cpu_ifetch #(
        .RESET_PC (RPC),
        .DEPTH    (DEPTH)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .stall          (stall),
        .p2_bubble      (p2_bubble),
        .p3_jump_taken  (p3_jump_taken),
        .p3_jump_target (p3_jump_target),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .p2_instr       (p2_instr),
        .p2_pc          (p2_pc),
        .p2_instr_valid (p2_instr_valid)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int lat   = 1;

    // Reference model: fetch pc, next response pc, in-flight and to-drop counts, buffered pcs.
    logic [31:0] m_pc;
    logic [31:0] m_resp_pc;
    int          m_out;
    int          m_disc;
    logic [31:0] m_q[$];

    typedef struct {
        int          due;
        logic [31:0] addr;
    } mem_t;
    mem_t mem_q[$];

    logic        s_req;
    logic [31:0] s_addr;
    logic [31:0] exp_next;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_pc      = RPC;
        m_resp_pc = RPC;
        m_out     = 0;
        m_disc    = 0;
        m_q.delete();
        mem_q.delete();
    endtask

    // Advance model and memory on each rising edge, then drive the memory response.
    task automatic tick();
        logic fl;
        logic pp;
        logic rq;
        logic fire;
        logic rv;
        @(posedge clock);
        if (reset) begin
            model_reset();
        end else begin
            rv   = imem_rvalid;
            fl   = p3_jump_taken && !stall;
            pp   = (m_q.size() > 0) && !stall && !p2_bubble;
            rq   = !fl && ((m_out + m_q.size()) < DEPTH);
            fire = rq && imem_gnt;
            if (rv && mem_q.size() > 0) void'(mem_q.pop_front());
            if (s_req && imem_gnt) mem_q.push_back('{due: cyc + lat, addr: s_addr});
            if (fl) begin
                m_q.delete();
                m_out     = m_out - int'(rv);
                m_disc    = m_out;
                m_pc      = word_align(p3_jump_target);
                m_resp_pc = word_align(p3_jump_target);
            end else begin
                if (pp) void'(m_q.pop_front());
                if (rv) begin
                    if (m_disc > 0) begin
                        m_disc--;
                    end else begin
                        m_q.push_back(m_resp_pc);
                        m_resp_pc = m_resp_pc + 32'd4;
                    end
                end
                m_out = m_out + int'(fire) - int'(rv);
                if (fire) m_pc = m_pc + 32'd4;
            end
        end
        cyc++;
        #1;
        if (!reset && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_q[0].addr ^ KEY;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
        end
    endtask

    initial forever tick();

    // Per-cycle comparison against the model, plus a consumed-pc continuity check.
    always @(negedge clock) begin
        logic fl;
        s_req  = imem_req;
        s_addr = imem_addr;
        if (reset) begin
            chk("rst_req", {31'h0, imem_req}, 32'h0);
            chk("rst_addr", imem_addr, RPC);
            chk("rst_valid", {31'h0, p2_instr_valid}, 32'h0);
            chk("rst_pc", p2_pc, RPC);
            chk("rst_instr", p2_instr, 32'h0);
            exp_next = RPC;
        end else begin
            fl = p3_jump_taken && !stall;
            chk("req", {31'h0, imem_req}, {31'h0, !fl && ((m_out + m_q.size()) < DEPTH)});
            chk("addr", imem_addr, m_pc);
            chk("valid", {31'h0, p2_instr_valid}, {31'h0, m_q.size() > 0});
            if (m_q.size() > 0) begin
                chk("head_pc", p2_pc, m_q[0]);
                chk("head_instr", p2_instr, m_q[0] ^ KEY);
            end
            if (p2_instr_valid && !stall && !p2_bubble) begin
                chk("consume_seq", p2_pc, exp_next);
                exp_next = exp_next + 32'd4;
            end
            if (fl) exp_next = word_align(p3_jump_target);
        end
    end

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic at_neg();
        @(negedge clock);
    endtask

    initial begin
        int          first_gnt;
        int          first_val;
        int          n08;
        int          t0;
        int          waited;
        logic        bub_done;
        logic        after_done;
        logic        got;
        logic        hv;
        logic [31:0] last_pc;
        logic [31:0] hpc;
        logic [31:0] hins;

        reset          = 1'b1;
        stall          = 1'b0;
        p2_bubble      = 1'b0;
        p3_jump_taken  = 1'b0;
        p3_jump_target = 32'h0;
        imem_gnt       = 1'b1;
        step();
        step();
        at_neg();
        chk("lit_rst_addr", imem_addr, 32'hFFFF0000);
        chk("lit_rst_pc", p2_pc, 32'hFFFF0000);
        step();
        reset = 1'b0;

        // Streaming from reset, with a one-cycle bubble while FFFF0008 is at the head.
        first_gnt  = -1;
        first_val  = -1;
        n08        = 0;
        bub_done   = 1'b0;
        after_done = 1'b0;
        last_pc    = 32'h0;
        for (int i = 0; i < 24; i++) begin
            if (!bub_done && p2_instr_valid && p2_pc == 32'hFFFF0008) begin
                p2_bubble = 1'b1;
                bub_done  = 1'b1;
            end else begin
                p2_bubble = 1'b0;
            end
            at_neg();
            if (i == 0) begin
                chk("lit_first_req", {31'h0, imem_req}, 32'h1);
                chk("lit_first_addr", imem_addr, 32'hFFFF0000);
            end
            if (imem_req && imem_gnt && first_gnt < 0) first_gnt = cyc;
            if (p2_instr_valid && first_val < 0) begin
                first_val = cyc;
                chk("lit_first_pc", p2_pc, 32'hFFFF0000);
                chk("lit_first_instr", p2_instr, 32'hA5A55A5A);
            end
            if (p2_instr_valid && p2_pc == 32'hFFFF0008) n08++;
            if (!after_done && p2_instr_valid && last_pc == 32'hFFFF0008
                && p2_pc != 32'hFFFF0008) begin
                chk("lit_after_bubble", p2_pc, 32'hFFFF000C);
                after_done = 1'b1;
            end
            if (p2_instr_valid) last_pc = p2_pc;
            step();
        end
        p2_bubble = 1'b0;
        chk("fetch_latency", first_val - first_gnt, 32'd2);
        chk("bubble_hold_cycles", n08, 32'd2);
        chk("bubble_followed", {31'h0, after_done}, 32'h1);

        // Stall for five cycles: head frozen once valid, requests stop at the credit limit.
        stall = 1'b1;
        hv    = 1'b0;
        hpc   = 32'h0;
        hins  = 32'h0;
        for (int i = 0; i < 5; i++) begin
            at_neg();
            if (hv) begin
                chk("stall_valid", {31'h0, p2_instr_valid}, 32'h1);
                chk("stall_pc", p2_pc, hpc);
                chk("stall_instr", p2_instr, hins);
            end else if (p2_instr_valid) begin
                hv   = 1'b1;
                hpc  = p2_pc;
                hins = p2_instr;
            end
            if (i == 4) chk("stall_req_low", {31'h0, imem_req}, 32'h0);
            step();
        end
        stall = 1'b0;
        for (int i = 0; i < 12; i++) begin
            imem_gnt = (i % 3 != 1);
            step();
        end
        imem_gnt = 1'b1;

        // Three-cycle memory; redirect once two requests are in flight.
        lat    = 3;
        waited = 0;
        while (m_out != 2 && waited < 30) begin
            step();
            waited++;
        end
        chk("credit_full_req", {31'h0, imem_req}, 32'h0);
        p3_jump_taken  = 1'b1;
        p3_jump_target = 32'h00001003;
        t0             = cyc;
        at_neg();
        chk("flush_no_req", {31'h0, imem_req}, 32'h0);
        step();
        p3_jump_taken = 1'b0;
        at_neg();
        chk("lit_redir_req", {31'h0, imem_req}, 32'h1);
        chk("lit_redir_addr", imem_addr, 32'h00001000);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (p2_instr_valid) begin
                got = 1'b1;
                chk("lit_redir_pc", p2_pc, 32'h00001000);
                chk("lit_redir_instr", p2_instr, 32'h5A5A4A5A);
                chk("redir_min_latency", {31'h0, (cyc - t0) >= 3}, 32'h1);
            end else begin
                at_neg();
            end
        end
        chk("redir_seen", {31'h0, got}, 32'h1);

        // One-cycle memory; redirect in a cycle where a response arrives into a non-empty FIFO.
        lat = 1;
        step();
        waited = 0;
        while (!(imem_rvalid && p2_instr_valid) && waited < 30) begin
            step();
            waited++;
        end
        chk("flush_rv_setup", {31'h0, imem_rvalid && p2_instr_valid}, 32'h1);
        p3_jump_taken  = 1'b1;
        p3_jump_target = 32'h00002000;
        step();
        p3_jump_taken = 1'b0;
        at_neg();
        chk("lit_flush_empty", {31'h0, p2_instr_valid}, 32'h0);
        chk("lit_flush_addr", imem_addr, 32'h00002000);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            at_neg();
            if (p2_instr_valid) begin
                got = 1'b1;
                chk("lit_flush_pc", p2_pc, 32'h00002000);
                chk("lit_flush_instr", p2_instr, 32'h5A5A7A5A);
            end
        end
        chk("flush_seen", {31'h0, got}, 32'h1);

        // Asynchronous reset mid-burst.
        for (int i = 0; i < 4; i++) step();
        @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        chk("lit_async_req", {31'h0, imem_req}, 32'h0);
        chk("lit_async_addr", imem_addr, 32'hFFFF0000);
        chk("lit_async_valid", {31'h0, p2_instr_valid}, 32'h0);
        chk("lit_async_pc", p2_pc, 32'hFFFF0000);
        chk("lit_async_instr", p2_instr, 32'h0);
        step();
        step();
        reset = 1'b0;
        at_neg();
        chk("lit_restart_req", {31'h0, imem_req}, 32'h1);
        chk("lit_restart_addr", imem_addr, 32'hFFFF0000);
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            at_neg();
            if (p2_instr_valid) begin
                got = 1'b1;
                chk("lit_restart_pc", p2_pc, 32'hFFFF0000);
            end
        end
        chk("restart_seen", {31'h0, got}, 32'h1);
        for (int i = 0; i < 6; i++) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
